// File: rtl/producer_submodule.sv
// rtl/producer_submodule.sv - phit-link packet source: header, send stamp and payload flits
//
// Builds a packet of max(req_length,2) flits on request and serialises each
// flit LSB-phit-first onto the phit link under out_ready backpressure.
//   flit 0 : header, {src_addr, dest_addr} at addr_place_in_header
//   flit 1 : timer[F-1:0] captured on the acceptance edge
//   flit k : k zero-extended (k >= 2)
//
// Ports:
//   clk, rs (async active-low), en (freezes everything when low)
//   req, req_length, dest_addr, src_addr, timer : request side
//   out_ready                                   : downstream accept
//   outdata, out_new, out_sent_req              : phit link
//   busy, done, sent_count                      : status
//
// Optional feature: define PRODUCER_SENT_COUNT_EN to build the 32-bit
// wrapping packet counter behind sent_count; otherwise it is tied to 0.
module producer_submodule #(
  parameter int flit_size                   = 1,
  parameter int floorplusone_log2_flit_size = 1,
  parameter int phit_size                   = 16,
  parameter int addr_length                 = 8,
  parameter int addr_place_in_header        = 0
) (
  input  logic                   clk,
  input  logic                   rs,
  input  logic                   en,
  input  logic                   req,
  input  logic [15:0]            req_length,
  input  logic [addr_length-1:0] dest_addr,
  input  logic [addr_length-1:0] src_addr,
  input  logic [127:0]           timer,
  input  logic                   out_ready,
  output logic [phit_size-1:0]   outdata,
  output logic                   out_new,
  output logic                   out_sent_req,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            sent_count
);

  localparam int F  = flit_size * phit_size;
  localparam int PW = floorplusone_log2_flit_size;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_STAMP, S_BODY} state_t;

  state_t                 state_q, state_d;
  logic [addr_length-1:0] dest_q, dest_d;
  logic [addr_length-1:0] src_q, src_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            flit_cnt_q, flit_cnt_d;
  logic [F-1:0]           stamp_q, stamp_d;
  logic [PW-1:0]          phit_idx_q, phit_idx_d;
  logic                   done_q, done_d;

  logic         busy_w;
  logic         last_phit;
  logic         last_flit;
  logic         xfer;
  logic         tail;
  logic [F-1:0] header;
  logic [F-1:0] flit_cur;

  // flit_cnt_q is the index of the flit currently on the link, so the
  // header (index 0) can never be the last flit because L >= 2.
  assign busy_w    = (state_q != S_IDLE);
  assign last_phit = (phit_idx_q == PW'(flit_size - 1));
  assign last_flit = (flit_cnt_q == (len_q - 16'd1));
  assign xfer      = busy_w & en & out_ready;
  assign tail      = xfer & last_phit & last_flit;

  always_comb begin
    header = '0;
    header[addr_place_in_header +: addr_length]               = dest_q;
    header[addr_place_in_header + addr_length +: addr_length] = src_q;
  end

  always_comb begin
    flit_cur = '0;
    case (state_q)
      S_HEAD:  flit_cur = header;
      S_STAMP: flit_cur = stamp_q;
      S_BODY:  flit_cur = F'(flit_cnt_q);
      default: flit_cur = '0;
    endcase
  end

  // Phit mux; IDLE yields an all-zero flit so outdata is 0 there.
  always_comb begin
    outdata = '0;
    for (int i = 0; i < flit_size; i++) begin
      if (phit_idx_q == PW'(i)) outdata = flit_cur[i*phit_size +: phit_size];
    end
  end

  assign out_new      = busy_w & en;
  assign out_sent_req = busy_w & ~(last_phit & last_flit);
  assign busy         = busy_w;
  assign done         = done_q;

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    src_d      = src_q;
    len_d      = len_q;
    stamp_d    = stamp_q;
    flit_cnt_d = flit_cnt_q;
    phit_idx_d = phit_idx_q;
    done_d     = tail;

    if (state_q == S_IDLE) begin
      if (en && req) begin
        state_d    = S_HEAD;
        dest_d     = dest_addr;
        src_d      = src_addr;
        len_d      = (req_length < 16'd2) ? 16'd2 : req_length;
        stamp_d    = timer[F-1:0];
        flit_cnt_d = '0;
        phit_idx_d = '0;
      end
    end else if (xfer) begin
      if (!last_phit) begin
        phit_idx_d = phit_idx_q + PW'(1);
      end else begin
        phit_idx_d = '0;
        flit_cnt_d = flit_cnt_q + 16'd1;
        case (state_q)
          S_HEAD:  state_d = S_STAMP;
          S_STAMP: state_d = (len_q == 16'd2) ? S_IDLE : S_BODY;
          S_BODY:  if (last_flit) state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q    <= S_IDLE;
      dest_q     <= '0;
      src_q      <= '0;
      len_q      <= '0;
      stamp_q    <= '0;
      flit_cnt_q <= '0;
      phit_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      len_q      <= len_d;
      stamp_q    <= stamp_d;
      flit_cnt_q <= flit_cnt_d;
      phit_idx_q <= phit_idx_d;
      done_q     <= done_d;
    end
  end

`ifdef PRODUCER_SENT_COUNT_EN
  logic [31:0] sent_count_q, sent_count_d;

  always_comb begin
    sent_count_d = sent_count_q;
    if (tail) sent_count_d = sent_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) sent_count_q <= '0;
    else     sent_count_q <= sent_count_d;
  end

  assign sent_count = sent_count_q;
`else
  assign sent_count = '0;
`endif

  // Only the low F bits of the global timer form the stamp.
  if (F < 128) begin : g_timer_hi
    logic unused_timer_hi;
    assign unused_timer_hi = ^timer[127:F];
  end

endmodule

// File: tb/tb_producer_submodule.sv
// tb/tb_producer_submodule.sv - scoreboard bench for producer_submodule
module tb_producer_submodule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rs, en, req, req2, out_ready;
  logic [15:0]  req_length, req_length2;
  logic [7:0]   dest_addr, src_addr;
  logic [127:0] timer;

  logic [15:0] outdata;
  logic        out_new, out_sent_req, busy, done;
  logic [31:0] sent_count;
  logic [7:0]  outdata2;
  logic        out_new2, out_sent_req2, busy2, done2;
  logic [31:0] sent_count2;

  producer_submodule dut (
    .clk(clk), .rs(rs), .en(en), .req(req), .req_length(req_length),
    .dest_addr(dest_addr), .src_addr(src_addr), .timer(timer),
    .out_ready(out_ready), .outdata(outdata), .out_new(out_new),
    .out_sent_req(out_sent_req), .busy(busy), .done(done),
    .sent_count(sent_count)
  );

  producer_submodule #(
    .flit_size(2), .floorplusone_log2_flit_size(2), .phit_size(8)
  ) dut2 (
    .clk(clk), .rs(rs), .en(en), .req(req2), .req_length(req_length2),
    .dest_addr(dest_addr), .src_addr(src_addr), .timer(timer),
    .out_ready(out_ready), .outdata(outdata2), .out_new(out_new2),
    .out_sent_req(out_sent_req2), .busy(busy2), .done(done2),
    .sent_count(sent_count2)
  );

  typedef struct {
    logic [15:0] data;
    logic        sr;
  } phit_t;

  phit_t exp_q[$];
  phit_t exp2_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_count = 0;
  int    cycle = 0;
  int    done_seen = 0;
  int    done_cycles[$];
  logic  done_exp = 1'b0;
  logic  done2_exp = 1'b0;
  int    rdy_mode = 0;
  bit    en_rand = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] exp_sc();
`ifdef PRODUCER_SENT_COUNT_EN
    return 32'(exp_count);
`else
    return 32'd0;
`endif
  endfunction

  // Reference packet: flit list from the packet rules, then sliced into phits.
  function automatic void push_pkt(int inst, int fs, int ps, logic [7:0] s,
                                   logic [7:0] d, int unsigned len_req,
                                   logic [127:0] tmr);
    int L = (len_req < 2) ? 2 : int'(len_req);
    int F = fs * ps;
    for (int k = 0; k < L; k++) begin
      logic [63:0] flit;
      phit_t p;
      if (k == 0)      flit = {48'd0, s, d};
      else if (k == 1) flit = tmr[63:0];
      else             flit = 64'(k);
      flit = flit & ((64'd1 << F) - 64'd1);
      for (int i = 0; i < fs; i++) begin
        p.data = 16'((flit >> (i * ps)) & ((64'd1 << ps) - 64'd1));
        p.sr   = !((k == L - 1) && (i == fs - 1));
        if (inst == 0) exp_q.push_back(p);
        else           exp2_q.push_back(p);
      end
    end
  endfunction

  always @(negedge clk) begin : mon0
    phit_t p;
    logic  tl;
    cycle++;
    tl = 1'b0;
    if (!rs) begin
      done_exp = 1'b0;
    end else begin
      chk("done_pulse", done, done_exp);
      if (done) begin
        done_seen++;
        done_cycles.push_back(cycle);
        chk("sent_count_at_done", sent_count, exp_sc());
      end
      if (!en) chk("out_new_en_low", out_new, 0);
      if (out_new && out_ready && en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_phit actual=%0h required=none", outdata);
        end else begin
          p = exp_q.pop_front();
          chk("outdata", outdata, p.data);
          chk("out_sent_req", out_sent_req, p.sr);
          if (!p.sr) begin
            tl = 1'b1;
            exp_count++;
          end
        end
      end
      done_exp = tl;
    end
  end

  always @(negedge clk) begin : mon1
    phit_t p;
    logic  tl;
    tl = 1'b0;
    if (!rs) begin
      done2_exp = 1'b0;
    end else begin
      chk("done2_pulse", done2, done2_exp);
      if (!en) chk("out_new2_en_low", out_new2, 0);
      if (out_new2 && out_ready && en) begin
        checks++;
        if (exp2_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_phit2 actual=%0h required=none", outdata2);
        end else begin
          p = exp2_q.pop_front();
          chk("outdata2", outdata2, p.data);
          chk("out_sent_req2", out_sent_req2, p.sr);
          tl = !p.sr;
        end
      end
      done2_exp = tl;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (en_rand) en = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scramble_inputs();
    req_length = 16'($urandom);
    src_addr   = 8'($urandom);
    dest_addr  = 8'($urandom);
    timer      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send(logic [7:0] s, logic [7:0] d, logic [15:0] len, logic [127:0] tmr);
    bit saved = en_rand;
    en_rand = 0;
    en = 1'b1;
    src_addr = s; dest_addr = d; req_length = len; timer = tmr; req = 1'b1;
    push_pkt(0, 1, 16, s, d, len, tmr);
    tick(1);
    req = 1'b0;
    chk("latency_busy", busy, 1);
    chk("latency_header", outdata, {s, d});
    scramble_inputs();
    en_rand = saved;
  endtask

  task automatic send2(logic [7:0] s, logic [7:0] d, logic [15:0] len, logic [127:0] tmr);
    bit saved = en_rand;
    en_rand = 0;
    en = 1'b1;
    src_addr = s; dest_addr = d; req_length2 = len; timer = tmr; req2 = 1'b1;
    push_pkt(1, 2, 8, s, d, len, tmr);
    tick(1);
    req2 = 1'b0;
    chk("latency2_busy", busy2, 1);
    chk("latency2_header_lo", outdata2, d);
    req_length2 = 16'($urandom);
    scramble_inputs();
    en_rand = saved;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 3000) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d pending required=0", name, exp_q.size() + exp2_q.size());
    end
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int start;
    logic [127:0] t;
    rs = 1'b0; en = 1'b1; req = 1'b0; req2 = 1'b0;
    req_length = '0; req_length2 = '0; src_addr = '0; dest_addr = '0; timer = '0;
    tick(2);
    chk("rst_outdata", outdata, 0);
    chk("rst_out_new", out_new, 0);
    chk("rst_out_sent_req", out_sent_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent_count", sent_count, 0);
    rs = 1'b1;
    tick(2);

    // Basic packet and length clamp.
    send(8'h12, 8'h34, 16'd4, 128'h0000_00A5);
    wait_idle("basic");
    send(8'h12, 8'h34, 16'd0, 128'h1111);
    wait_idle("clamp0");
    send(8'h56, 8'h78, 16'd1, 128'h2222);
    wait_idle("clamp1");

    // Multi-phit flits.
    send2(8'h12, 8'h34, 16'd3, 128'hBEEF);
    wait_idle("multiphit");

    // Toggling ready with an enable drop mid-body.
    rdy_mode = 1;
    send(8'h12, 8'h34, 16'd4, 128'h0000_00A5);
    tick(4);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    wait_idle("bp_en");
    rdy_mode = 0;

    // Request during BODY must be dropped, not queued.
    send(8'h9A, 8'hBC, 16'd8, 128'h3333);
    tick(3);
    req = 1'b1; req_length = 16'd5;
    tick(1);
    req = 1'b0;
    wait_idle("ignored_req");
    tick(3);
    chk("ignored_req_idle", busy, 0);

    // Randomised traffic with random ready and enable.
    rdy_mode = 2;
    en_rand = 1;
    for (int n = 0; n < 12; n++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      send(8'($urandom), 8'($urandom), 16'($urandom_range(0, 9)), t);
      wait_idle("random");
    end
    for (int n = 0; n < 3; n++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      send2(8'($urandom), 8'($urandom), 16'($urandom_range(0, 5)), t);
      wait_idle("random2");
    end
    en_rand = 0;
    en = 1'b1;
    rdy_mode = 0;
    tick(1);

    // Asynchronous reset mid-packet.
    send(8'h5A, 8'hC3, 16'd8, 128'h4444);
    tick(3);
    #2;
    exp_q.delete();
    rs = 1'b0;
    #1;
    chk("arst_outdata", outdata, 0);
    chk("arst_out_new", out_new, 0);
    chk("arst_out_sent_req", out_sent_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sent_count", sent_count, 0);
    exp_count = 0;
    tick(2);
    rs = 1'b1;
    tick(1);
    send(8'h21, 8'h43, 16'd2, 128'h5555);
    wait_idle("post_reset");

    // Back-to-back packets with req held high.
    rs = 1'b0;
    tick(1);
    exp_count = 0;
    rs = 1'b1;
    tick(1);
    start = done_cycles.size();
    src_addr = 8'h0F; dest_addr = 8'hF0; req_length = 16'd3; timer = 128'h6666;
    for (int n = 0; n < 5; n++) push_pkt(0, 1, 16, 8'h0F, 8'hF0, 3, 128'h6666);
    req = 1'b1;
    begin
      int n = 0;
      while (done_cycles.size() < start + 4 && n < 200) begin
        tick(1);
        n++;
      end
    end
    tick(1);
    req = 1'b0;
    wait_idle("back_to_back");
    tick(2);
    chk("b2b_done_pulses", done_cycles.size() - start, 5);
    if (done_cycles.size() >= start + 5) begin
      for (int j = 1; j < 5; j++)
        chk("b2b_gap", done_cycles[start + j] - done_cycles[start + j - 1], 4);
    end
`ifdef PRODUCER_SENT_COUNT_EN
    chk("sent_count_final", sent_count, 5);
`else
    chk("sent_count_final", sent_count, 0);
`endif
    chk("queues_drained", exp_q.size() + exp2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
